control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 No parameters.
REQ-002 Clk  in  1  single clock; all state changes on rising edge.
REQ-003 Reset  in  1  reset, synchronous and active-high.
REQ-004 Opcode  in  6  instruction bits [31:26] from instruction register.
REQ-005 Funct  in  6  instruction bits [5:0] from instruction register.
REQ-006 Zero  in  1  ALU zero flag.
REQ-007 Overflow  in  1  ALU signed-overflow flag.
REQ-008 PC_load  out  1  PC register load.
REQ-009 IorD  out  1  memory address select: 0=PC, 1=AluOut.
REQ-010 wr  out  1  memory write (1) / read (0).
REQ-011 IRWrite  out  1  instruction register load.
REQ-012 MDR_load  out  1  memory data register load.
REQ-013 A_load  out  1  A register load.
REQ-014 B_load  out  1  B register load.
REQ-015 ALUOut_load  out  1  ALUOut register load.
REQ-016 ALUSrcA  out  1  ALU LHS select: 0=PC, 1=A.
REQ-017 ALUSrcB  out  2  ALU RHS select: 00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2.
REQ-018 ALUOp  out  2  00=add, 01=sub, 10=decode from Funct, 11=reserved (never driven).
REQ-019 PCSource  out  2  next-PC select: 00=ALU, 01=AluOut, 10=jump target, 11=exception vector.
REQ-020 RegDst  out  1  write-register select: 0=rt, 1=rd.
REQ-021 MemtoReg  out  1  register write data: 0=AluOut, 1=MDR.
REQ-022 RegWrite  out  1  register bank write.
REQ-023 EPCWrite  out  1  EPC register load.
REQ-024 Estado  out  8  current state code.

Function
REQ-025 Moore FSM: every output except PC_load is decoded from the state register only; Estado equals the state code.
REQ-026 State codes: RESET=0, FETCH=1, FETCH_WAIT=2, DECODE=3, MEMADR=4, MEMREAD=5, MEMREAD_WAIT=6, MEMWB=7, MEMWRITE=8, RTYPE_EX=9, RTYPE_WB=10, BEQ=11, BNE=12, JUMP=13, ADDI_EX=14, ADDI_WB=15, EXCEPTION=16, HALT=17; all other codes go to RESET.
REQ-027 Any output not listed for a state is 0.
REQ-028 RESET -> FETCH unconditionally.
REQ-029 FETCH: IorD=0, wr=0; -> FETCH_WAIT. Memory read data is valid one cycle after the address.
REQ-030 FETCH_WAIT: IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PC_load=1 (PC<=PC+4); -> DECODE.
REQ-031 DECODE: A_load=B_load=1, ALUSrcA=0, ALUSrcB=11, ALUOp=00, ALUOut_load=1 (branch target).
REQ-032 DECODE dispatch on Opcode: 0x23/0x2B->MEMADR; 0x00->RTYPE_EX, or HALT when Funct=0x0D; 0x04->BEQ; 0x05->BNE; 0x02->JUMP; 0x08->ADDI_EX; any other value->EXCEPTION.
REQ-033 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ALUOut_load=1; -> MEMREAD when Opcode=0x23, else MEMWRITE.
REQ-034 MEMREAD: IorD=1, wr=0; -> MEMREAD_WAIT. MEMREAD_WAIT: MDR_load=1; -> MEMWB.
REQ-035 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-036 MEMWRITE: IorD=1, wr=1; -> FETCH.
REQ-037 RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10, ALUOut_load=1. Next state is EXCEPTION when Overflow=1 and Funct is 0x20 or 0x22; otherwise RTYPE_WB.
REQ-038 RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-039 ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ALUOut_load=1. Next state is EXCEPTION when Overflow=1, else ADDI_WB.
REQ-040 ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-041 BEQ and BNE: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - BEQ: PC_load=Zero.
  - BNE: PC_load=~Zero.
  - Both -> FETCH.
  - PC_load is combinational on Zero only in these two states.
REQ-042 JUMP: PCSource=10, PC_load=1; -> FETCH.
REQ-043 EXCEPTION: ALUSrcA=0, ALUSrcB=01, ALUOp=01 (ALU=PC-4), EPCWrite=1, PCSource=11, PC_load=1; -> FETCH.
REQ-044 HALT: all outputs 0; remains in HALT until Reset.
REQ-045 Never assert wr and RegWrite in the same cycle. Never assert IRWrite outside FETCH_WAIT.

Reset
REQ-046 Reset=1 at a clock edge forces state RESET and Estado=0x00 with all outputs 0, from any state (including mid-instruction and HALT); it has priority over every transition.
REQ-047 The first edge with Reset=0 moves RESET to FETCH.

Verification
REQ-048 Reset, then Opcode=0x23 -> Estado 0,1,2,3,4,5,6,7,1; RegWrite=1 and MemtoReg=1 only in state 7.
REQ-049 Opcode=0x04 with Zero=1 -> PC_load=1 and PCSource=01 in state 11. Repeat with Zero=0 -> PC_load=0.
REQ-050 Opcode=0x00, Funct=0x20, Overflow=1 in RTYPE_EX -> next Estado=16 with EPCWrite=1 and PCSource=11; RegWrite never asserted.
REQ-051 Opcode=0x3F -> DECODE goes to EXCEPTION (16), then FETCH (1).
REQ-052 Opcode=0x00, Funct=0x0D -> HALT (17) held for 10 cycles; Reset -> Estado=0 on the next edge.
REQ-053 Opcode=0x2B with Reset asserted in MEMADR -> Estado=0 on the next edge, and wr is never asserted.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode, execute,
// memory and write-back phases, with overflow/illegal-opcode exception and HALT.
module control_unit (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       Overflow,
   output logic       PC_load,
   output logic       IorD,
   output logic       wr,
   output logic       IRWrite,
   output logic       MDR_load,
   output logic       A_load,
   output logic       B_load,
   output logic       ALUOut_load,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       EPCWrite,
   output logic [7:0] Estado
);

   localparam logic [7:0] S_RESET        = 8'd0;
   localparam logic [7:0] S_FETCH        = 8'd1;
   localparam logic [7:0] S_FETCH_WAIT   = 8'd2;
   localparam logic [7:0] S_DECODE       = 8'd3;
   localparam logic [7:0] S_MEMADR       = 8'd4;
   localparam logic [7:0] S_MEMREAD      = 8'd5;
   localparam logic [7:0] S_MEMREAD_WAIT = 8'd6;
   localparam logic [7:0] S_MEMWB        = 8'd7;
   localparam logic [7:0] S_MEMWRITE     = 8'd8;
   localparam logic [7:0] S_RTYPE_EX     = 8'd9;
   localparam logic [7:0] S_RTYPE_WB     = 8'd10;
   localparam logic [7:0] S_BEQ          = 8'd11;
   localparam logic [7:0] S_BNE          = 8'd12;
   localparam logic [7:0] S_JUMP         = 8'd13;
   localparam logic [7:0] S_ADDI_EX      = 8'd14;
   localparam logic [7:0] S_ADDI_WB      = 8'd15;
   localparam logic [7:0] S_EXCEPTION    = 8'd16;
   localparam logic [7:0] S_HALT         = 8'd17;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   logic [7:0] state_reg;
   logic [7:0] state_next;

   always_ff @(posedge Clk) begin
      if (Reset)
         state_reg <= S_RESET;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = S_RESET;
      case (state_reg)
         S_RESET:        state_next = S_FETCH;
         S_FETCH:        state_next = S_FETCH_WAIT;
         S_FETCH_WAIT:   state_next = S_DECODE;
         S_DECODE: begin
            case (Opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = (Funct == 6'h0D) ? S_HALT : S_RTYPE_EX;
               OP_BEQ:       state_next = S_BEQ;
               OP_BNE:       state_next = S_BNE;
               OP_J:         state_next = S_JUMP;
               OP_ADDI:      state_next = S_ADDI_EX;
               default:      state_next = S_EXCEPTION;
            endcase
         end
         S_MEMADR:       state_next = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:      state_next = S_MEMREAD_WAIT;
         S_MEMREAD_WAIT: state_next = S_MEMWB;
         S_MEMWB:        state_next = S_FETCH;
         S_MEMWRITE:     state_next = S_FETCH;
         // Only signed add/sub trap on overflow; addu/subu and logic ops do not.
         S_RTYPE_EX:     state_next = (Overflow && (Funct == 6'h20 || Funct == 6'h22))
                                      ? S_EXCEPTION : S_RTYPE_WB;
         S_RTYPE_WB:     state_next = S_FETCH;
         S_BEQ:          state_next = S_FETCH;
         S_BNE:          state_next = S_FETCH;
         S_JUMP:         state_next = S_FETCH;
         S_ADDI_EX:      state_next = Overflow ? S_EXCEPTION : S_ADDI_WB;
         S_ADDI_WB:      state_next = S_FETCH;
         S_EXCEPTION:    state_next = S_FETCH;
         S_HALT:         state_next = S_HALT;
         default:        state_next = S_RESET;
      endcase
   end

   always_comb begin
      PC_load     = 1'b0;
      IorD        = 1'b0;
      wr          = 1'b0;
      IRWrite     = 1'b0;
      MDR_load    = 1'b0;
      A_load      = 1'b0;
      B_load      = 1'b0;
      ALUOut_load = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      EPCWrite    = 1'b0;
      case (state_reg)
         S_FETCH_WAIT: begin
            IRWrite = 1'b1;
            ALUSrcB = 2'b01;
            PC_load = 1'b1;
         end
         S_DECODE: begin
            A_load      = 1'b1;
            B_load      = 1'b1;
            ALUSrcB     = 2'b11;
            ALUOut_load = 1'b1;
         end
         S_MEMADR, S_ADDI_EX: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            ALUOut_load = 1'b1;
         end
         S_MEMREAD:      IorD = 1'b1;
         S_MEMREAD_WAIT: MDR_load = 1'b1;
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWRITE: begin
            IorD = 1'b1;
            wr   = 1'b1;
         end
         S_RTYPE_EX: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b10;
            ALUOut_load = 1'b1;
         end
         S_RTYPE_WB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         // The branch compare happens this cycle, so PC_load follows Zero directly.
         S_BEQ, S_BNE: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 2'b01;
            PCSource = 2'b01;
            PC_load  = (state_reg == S_BEQ) ? Zero : ~Zero;
         end
         S_JUMP: begin
            PCSource = 2'b10;
            PC_load  = 1'b1;
         end
         S_ADDI_WB:      RegWrite = 1'b1;
         S_EXCEPTION: begin
            ALUSrcB  = 2'b01;
            ALUOp    = 2'b01;
            EPCWrite = 1'b1;
            PCSource = 2'b11;
            PC_load  = 1'b1;
         end
         default: ;
      endcase
   end

   assign Estado = state_reg;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level model predicts the state
// walk and the control word of each state, compared cycle by cycle.
module tb_control_unit;

   logic       Clk;
   logic       Reset;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       Zero;
   logic       Overflow;
   logic       PC_load, IorD, wr, IRWrite, MDR_load, A_load, B_load, ALUOut_load;
   logic       ALUSrcA, RegDst, MemtoReg, RegWrite, EPCWrite;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [7:0] Estado;

   int checks = 0;
   int errors = 0;
   int seq[$];

   control_unit dut (
      .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .Overflow(Overflow), .PC_load(PC_load), .IorD(IorD), .wr(wr), .IRWrite(IRWrite),
      .MDR_load(MDR_load), .A_load(A_load), .B_load(B_load), .ALUOut_load(ALUOut_load),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .EPCWrite(EPCWrite),
      .Estado(Estado)
   );

   // {PC_load,IorD,wr,IRWrite,MDR_load,A_load,B_load,ALUOut_load,ALUSrcA,ALUSrcB,ALUOp,PCSource,RegDst,MemtoReg,RegWrite,EPCWrite}
   logic [18:0] obs;
   assign obs = {PC_load, IorD, wr, IRWrite, MDR_load, A_load, B_load, ALUOut_load, ALUSrcA,
                 ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg, RegWrite, EPCWrite};

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Control word table transcribed from the per-state output rules.
   function automatic logic [18:0] exp_out(input int s, input logic z);
      case (s)
         2:  return 19'b1_0_0_1_0_0_0_0_0_01_00_00_0_0_0_0;
         3:  return 19'b0_0_0_0_0_1_1_1_0_11_00_00_0_0_0_0;
         4:  return 19'b0_0_0_0_0_0_0_1_1_10_00_00_0_0_0_0;
         5:  return 19'b0_1_0_0_0_0_0_0_0_00_00_00_0_0_0_0;
         6:  return 19'b0_0_0_0_1_0_0_0_0_00_00_00_0_0_0_0;
         7:  return 19'b0_0_0_0_0_0_0_0_0_00_00_00_0_1_1_0;
         8:  return 19'b0_1_1_0_0_0_0_0_0_00_00_00_0_0_0_0;
         9:  return 19'b0_0_0_0_0_0_0_1_1_00_10_00_0_0_0_0;
         10: return 19'b0_0_0_0_0_0_0_0_0_00_00_00_1_0_1_0;
         11: return {z,  18'b0_0_0_0_0_0_0_1_00_01_01_0_0_0_0};
         12: return {~z, 18'b0_0_0_0_0_0_0_1_00_01_01_0_0_0_0};
         13: return 19'b1_0_0_0_0_0_0_0_0_00_00_10_0_0_0_0;
         14: return 19'b0_0_0_0_0_0_0_1_1_10_00_00_0_0_0_0;
         15: return 19'b0_0_0_0_0_0_0_0_0_00_00_00_0_0_1_0;
         16: return 19'b1_0_0_0_0_0_0_0_0_01_01_11_0_0_0_1;
         default: return 19'b0;
      endcase
   endfunction

   // State walk of one instruction, from FETCH up to (not including) the next FETCH.
   function automatic void build_seq(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
      seq = '{1, 2, 3};
      case (op)
         6'h23: seq = {seq, 4, 5, 6, 7};
         6'h2B: seq = {seq, 4, 8};
         6'h00: begin
            if (fn == 6'h0D) seq.push_back(17);
            else begin
               seq.push_back(9);
               seq.push_back((ovf && (fn == 6'h20 || fn == 6'h22)) ? 16 : 10);
            end
         end
         6'h04: seq.push_back(11);
         6'h05: seq.push_back(12);
         6'h02: seq.push_back(13);
         6'h08: seq = {seq, 14, ovf ? 16 : 15};
         default: seq.push_back(16);
      endcase
   endfunction

   task automatic test_reset();
      Reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         Opcode = 6'($urandom); Funct = 6'($urandom);
         Zero = 1'($urandom); Overflow = 1'($urandom);
         step();
         checks++;
         if (Estado !== 8'd0 || obs !== 19'b0) begin
            errors++;
            $display("FAIL reset_hold: Estado=%0d outputs=%b, required 0 / all zero", Estado, obs);
         end
      end
      Reset = 1'b0;
      step();
      checks++;
      if (Estado !== 8'd1) begin
         errors++;
         $display("FAIL reset_release: Estado=%0d, required 1", Estado);
      end
      $display("reset: released into FETCH, Estado=%0d", Estado);
   endtask

   task automatic test_directed();
      logic [5:0] op_t [12] = '{6'h23, 6'h2B, 6'h04, 6'h04, 6'h05, 6'h05, 6'h02, 6'h08, 6'h08, 6'h00, 6'h00, 6'h3F};
      logic [5:0] fn_t [12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h22, 6'h00};
      logic       z_t  [12] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
      logic       v_t  [12] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
      for (int k = 0; k < 12; k++) begin
         Opcode = op_t[k]; Funct = fn_t[k]; Zero = z_t[k]; Overflow = v_t[k];
         build_seq(Opcode, Funct, Overflow);
         for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (Estado !== 8'(seq[i]) || obs !== exp_out(seq[i], Zero)) begin
               errors++;
               $display("FAIL directed_%0d step %0d: Estado=%0d outputs=%b, required %0d / %b",
                        k, i, Estado, obs, seq[i], exp_out(seq[i], Zero));
            end
            checks++;
            if ((wr && RegWrite) || (IRWrite && Estado !== 8'd2)) begin
               errors++;
               $display("FAIL directed_invariant_%0d: Estado=%0d wr=%b RegWrite=%b IRWrite=%b", k, Estado, wr, RegWrite, IRWrite);
            end
            step();
         end
         $display("directed op=%h funct=%h zero=%b ovf=%b: %0d states, now Estado=%0d", Opcode, Funct, Zero, Overflow, seq.size(), Estado);
      end
   endtask

   task automatic test_reset_mid_store();
      int wr_seen = 0;
      Opcode = 6'h2B; Funct = 6'h00; Zero = 1'b0; Overflow = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (wr) wr_seen++;
         checks++;
         if (Estado !== 8'(i)) begin
            errors++;
            $display("FAIL store_walk: Estado=%0d, required %0d", Estado, i);
         end
         if (i < 4) step();
      end
      Reset = 1'b1;
      step();
      if (wr) wr_seen++;
      checks++;
      if (Estado !== 8'd0 || obs !== 19'b0) begin
         errors++;
         $display("FAIL store_reset: Estado=%0d outputs=%b, required 0 / all zero", Estado, obs);
      end
      Reset = 1'b0;
      step();
      if (wr) wr_seen++;
      checks++;
      if (Estado !== 8'd1 || wr_seen !== 0) begin
         errors++;
         $display("FAIL store_abort: Estado=%0d wr_cycles=%0d, required 1 / 0", Estado, wr_seen);
      end
      $display("store reset in MEMADR: Estado=%0d wr_cycles=%0d", Estado, wr_seen);
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [9] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3F, 6'h00};
      logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h21, 6'h24, 6'h25, 6'h2A};
      for (int k = 0; k < 60; k++) begin
         Opcode = ops[$urandom_range(0, 8)];
         if (k % 7 == 6) Opcode = 6'($urandom);
         Funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
         if (Opcode == 6'h00 && Funct == 6'h0D) Funct = 6'h20;
         Zero = 1'($urandom); Overflow = 1'($urandom);
         build_seq(Opcode, Funct, Overflow);
         for (int i = 0; i < seq.size(); i++) begin
            checks++;
            if (Estado !== 8'(seq[i]) || obs !== exp_out(seq[i], Zero)) begin
               errors++;
               $display("FAIL random_%0d step %0d: Estado=%0d outputs=%b, required %0d / %b",
                        k, i, Estado, obs, seq[i], exp_out(seq[i], Zero));
            end
            checks++;
            if ((wr && RegWrite) || (IRWrite && Estado !== 8'd2)) begin
               errors++;
               $display("FAIL random_invariant_%0d: Estado=%0d wr=%b RegWrite=%b IRWrite=%b", k, Estado, wr, RegWrite, IRWrite);
            end
            step();
         end
         $display("random op=%h funct=%h zero=%b ovf=%b: %0d states", Opcode, Funct, Zero, Overflow, seq.size());
      end
   endtask

   task automatic test_halt();
      Opcode = 6'h00; Funct = 6'h0D; Overflow = 1'b0; Zero = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         checks++;
         if (Estado !== 8'(i)) begin
            errors++;
            $display("FAIL halt_walk: Estado=%0d, required %0d", Estado, i);
         end
         step();
      end
      for (int i = 0; i < 10; i++) begin
         Zero = 1'($urandom); Overflow = 1'($urandom); Opcode = 6'($urandom);
         checks++;
         if (Estado !== 8'd17 || obs !== 19'b0) begin
            errors++;
            $display("FAIL halt_hold cycle %0d: Estado=%0d outputs=%b, required 17 / all zero", i, Estado, obs);
         end
         step();
      end
      Reset = 1'b1;
      step();
      checks++;
      if (Estado !== 8'd0 || obs !== 19'b0) begin
         errors++;
         $display("FAIL halt_reset: Estado=%0d outputs=%b, required 0 / all zero", Estado, obs);
      end
      Reset = 1'b0;
      step();
      checks++;
      if (Estado !== 8'd1) begin
         errors++;
         $display("FAIL halt_restart: Estado=%0d, required 1", Estado);
      end
      $display("halt: held 10 cycles, reset restarts at Estado=%0d", Estado);
   endtask

   initial begin
      Reset = 1'b1; Opcode = 6'h00; Funct = 6'h00; Zero = 1'b0; Overflow = 1'b0;
      test_reset();
      test_directed();
      test_reset_mid_store();
      test_back_to_back();
      test_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
